dds_waveform_generator: RTL and testbench
=========================================

Name: dds_waveform_generator

Overview:
Parametrised direct-digital-synthesis successor to the fixed-rate sine generator. A phase accumulator is advanced by a runtime frequency tuning word (FTW), so there is no clock divider. The phase is folded into a quarter-wave sine ROM or into computed triangle, square or sawtooth waveforms. Each sample is then scaled by a runtime amplitude and emitted as offset-binary through a 3-stage pipeline to the DAC interface.

Parameters:
PHASE_WIDTH, 32, accumulator/FTW/offset width (P)
LUT_ADDR_WIDTH, 8, log2 of quarter-wave ROM entries (L); requires L+2 <= P
DATA_WIDTH, 8, output sample width (D); requires D+1 <= P
AMP_WIDTH, 8, amplitude control width (A)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = accumulator advances by FTW each cycle
ftw_in  in  P  frequency tuning word
ftw_load  in  1  1-cycle strobe; captures ftw_in
phase_offset  in  P  phase added after accumulator
wave_sel  in  2  0 sine, 1 triangle, 2 square, 3 sawtooth
amplitude  in  A  gain = (amplitude+1)/2^A
wave_out  out  D  offset-binary sample, midscale = 2^(D-1)
wave_valid  out  1  high when wave_out derives from an enabled phase step
phase_wrap  out  1  1-cycle pulse aligned with first sample after accumulator carry-out

Behaviour:
- Reset (async assert, sync deassert handled upstream): acc=0, ftw_reg=0, all pipe regs 0, wave_out=2^(D-1), wave_valid=0, phase_wrap=0. Reset mid-run returns outputs to these values immediately; no partial state survives.
- ftw_load=1 in cycle T: ftw_reg=ftw_in from T+1, so the first step using it occurs at T+1 (subject to optional feature).
- acc: if enable, acc <= acc + ftw_reg mod 2^P; carry-out sets wrap flag into pipe. If !enable, acc holds and the pipe continues with the frozen phase.
- S1 (reg): ph = acc + phase_offset mod 2^P. wave_sel, amplitude, enable and wrap are captured alongside, so all controls take effect coherently.
- S2 (reg): signed sample s, range +/-(2^(D-1)-1):
  - Sine: q=ph[P-1:P-2], idx=ph[P-3 -: L]; idx inverted if q[0]. ROM Q[i]=round((2^(D-1)-1)*sin(pi/2*(i+0.5)/2^L)), built at elaboration by constant function. s=q[1] ? -Q : Q.
  - Triangle: r=ph[P-2 -: D]; u=ph[P-1] ? ~r : r; s=u-2^(D-1), with -2^(D-1) clamped to -(2^(D-1)-1).
  - Square: s=ph[P-1] ? -(2^(D-1)-1) : +(2^(D-1)-1).
  - Sawtooth: s=ph[P-1 -: D]-2^(D-1), clamped as for triangle.
- S3 (reg): wave_out = 2^(D-1) + ((s*(amplitude+1)) >>> A), arithmetic shift (floor). Product width D+A+1; no overflow is possible.
- Latency: acc value of cycle T appears on wave_out at T+3; ftw_load to first affected sample is 4 cycles.
- wave_valid and phase_wrap are pipe-delayed copies of enable and carry; both are 0 for the first 3 cycles after reset.
- ftw_reg=0 with enable=1: constant output, wave_valid=1, no wraps.
- wave_sel or amplitude change: glitch-free, and applies from the next S1 capture.

Optional Feature:
DDS_FTW_SHADOW_EN
- Defined: ftw_load writes a shadow register; ftw_reg <= shadow only on the cycle an accumulator carry-out occurs, giving phase-continuous frequency changes at period boundaries. A second load before the wrap overwrites the shadow. Reset clears the shadow.
- Undefined: ftw_reg updates the cycle after ftw_load, as described in Behaviour.

Test Plan (P=32, L=8, D=8, A=8):
1. rst_n=0 mid-run with enable=1 -> same cycle wave_out=128, wave_valid=0, phase_wrap=0; after release, first valid sample 3 cycles after acc first steps.
2. ftw=2^24, sine, amplitude=255, offset=0 -> period 256 cycles; sample for acc=0 is 128; acc=2^30-2^24 gives 255; acc=3*2^30-2^24 gives 1; phase_wrap every 256 cycles.
3. Square, amplitude=127 -> outputs alternate 191/64 every 128 samples.
4. Sawtooth, amplitude=255, ftw=2^24 -> wave_out = acc[31:24] delayed 3 cycles, except 0 is clamped to 1; triangle peaks at 255, trough at 1.
5. phase_offset=2^30 with sine -> output equals the offset=0 trace shifted 64 samples; enable=0 for 10 cycles -> wave_out frozen and wave_valid low, aligned 3 cycles later.
6. DDS_FTW_SHADOW_EN: load 2^25 mid-period at ftw=2^24 -> old rate persists until wrap, then new rate from acc=0. Without macro -> new rate after 1 cycle.

Source files
------------

// File: rtl/dds_waveform_generator.sv
// dds_waveform_generator: direct-digital-synthesis waveform source.
// A phase accumulator stepped by a runtime tuning word drives a quarter-wave
// sine ROM or computed triangle/square/sawtooth shapes. Samples are scaled by
// a runtime amplitude and emitted as offset-binary after a 3-stage pipeline.
// Optional feature macro: DDS_FTW_SHADOW_EN (tuning word changes take effect
// only at accumulator wrap, for phase-continuous frequency hops).
module dds_waveform_generator #(
  parameter int unsigned PHASE_WIDTH    = 32,
  parameter int unsigned LUT_ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned AMP_WIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [PHASE_WIDTH-1:0] ftw_in,
  input  logic                   ftw_load,
  input  logic [PHASE_WIDTH-1:0] phase_offset,
  input  logic [1:0]             wave_sel,
  input  logic [AMP_WIDTH-1:0]   amplitude,
  output logic [DATA_WIDTH-1:0]  wave_out,
  output logic                   wave_valid,
  output logic                   phase_wrap
);

  localparam int unsigned P = PHASE_WIDTH;
  localparam int unsigned L = LUT_ADDR_WIDTH;
  localparam int unsigned D = DATA_WIDTH;
  localparam int unsigned A = AMP_WIDTH;

  localparam logic [D-1:0] MID      = {1'b1, {(D-1){1'b0}}};
  localparam logic [D-1:0] POS_FULL = {1'b0, {(D-1){1'b1}}};
  localparam logic [D-1:0] NEG_FULL = {1'b1, {(D-2){1'b0}}, 1'b1};

  // pi/2 in Q30 fixed point
  localparam longint HALF_PI_Q30 = 64'sd1686629713;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_TRI    = 2'd1,
    WAVE_SQUARE = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

  // Quarter-wave entry i: round((2^(D-1)-1) * sin(pi/2 * (i+0.5) / 2^L)).
  // Evaluated with a Q30 Taylor series so elaboration needs no real math.
  function automatic longint sine_q(input int unsigned i);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (HALF_PI_Q30 * longint'(2 * i + 1)) >>> (L + 1);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int unsigned k = 1; k <= 8; k++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
      sum  = sum + term;
    end
    return (longint'(POS_FULL) * sum + (longint'(1) <<< 29)) >>> 30;
  endfunction

  // Map an unsigned ramp code to a signed sample symmetric about zero.
  function automatic logic [D-1:0] center(input logic [D-1:0] u);
    return (u == '0) ? NEG_FULL : {~u[D-1], u[D-2:0]};
  endfunction

  logic [D-2:0] rom [2**L];

  for (genvar g = 0; g < 2**L; g++) begin : g_rom
    localparam longint QV = sine_q(g);
    assign rom[g] = QV[D-2:0];
  end

  // Accumulator and tuning word
  logic [P-1:0] acc;
  logic [P-1:0] ftw_reg;
  logic [P:0]   sum_ext;
  logic         carry;
  logic         carry_q;

  // Next accumulator value and carry-out for this cycle's step
  always_comb begin
    sum_ext = {1'b0, acc} + {1'b0, ftw_reg};
    carry   = enable & sum_ext[P];
  end

  // Accumulator holds while disabled; carry flag travels with its phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      carry_q <= 1'b0;
    end else begin
      if (enable) begin
        acc <= sum_ext[P-1:0];
      end
      carry_q <= carry;
    end
  end

`ifdef DDS_FTW_SHADOW_EN
  logic [P-1:0] ftw_shadow;

  // Loads park in the shadow and move into ftw_reg at a period boundary.
  // A zero rate never wraps, so the transfer is also taken while ftw_reg is
  // zero; the phase is stationary then, so continuity is unaffected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_shadow <= '0;
      ftw_reg    <= '0;
    end else begin
      if (ftw_load) begin
        ftw_shadow <= ftw_in;
      end
      if (carry || (ftw_reg == '0)) begin
        ftw_reg <= ftw_load ? ftw_in : ftw_shadow;
      end
    end
  end
`else
  // Tuning word takes effect the cycle after the load strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_reg <= '0;
    end else if (ftw_load) begin
      ftw_reg <= ftw_in;
    end
  end
`endif

  // Stage 1: offset phase plus all controls, captured together
  logic [P-1:0] ph_s1;
  wave_e        sel_s1;
  logic [A-1:0] amp_s1;
  logic         en_s1;
  logic         wrap_s1;

  // Capture phase and controls so a control change applies coherently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_s1   <= '0;
      sel_s1  <= WAVE_SINE;
      amp_s1  <= '0;
      en_s1   <= 1'b0;
      wrap_s1 <= 1'b0;
    end else begin
      ph_s1   <= acc + phase_offset;
      sel_s1  <= wave_e'(wave_sel);
      amp_s1  <= amplitude;
      en_s1   <= enable;
      wrap_s1 <= carry_q;
    end
  end

  // Stage 2: signed sample generation
  logic [1:0]   quad;
  logic [L-1:0] idx;
  logic [D-1:0] mag;
  logic [D-1:0] ramp;
  logic [D-1:0] s_next;

  // Waveform shaping from the stage-1 phase
  always_comb begin
    quad   = ph_s1[P-1 -: 2];
    idx    = ph_s1[P-3 -: L];
    mag    = '0;
    ramp   = '0;
    s_next = '0;
    if (quad[0]) begin
      idx = ~idx;
    end
    unique case (sel_s1)
      WAVE_SINE: begin
        mag    = {1'b0, rom[idx]};
        s_next = quad[1] ? ('0 - mag) : mag;
      end
      WAVE_TRI: begin
        ramp   = ph_s1[P-1] ? ~ph_s1[P-2 -: D] : ph_s1[P-2 -: D];
        s_next = center(ramp);
      end
      WAVE_SQUARE: begin
        s_next = ph_s1[P-1] ? NEG_FULL : POS_FULL;
      end
      WAVE_SAW: begin
        ramp   = ph_s1[P-1 -: D];
        s_next = center(ramp);
      end
      default: s_next = '0;
    endcase
  end

  logic [D-1:0] s_s2;
  logic [A-1:0] amp_s2;
  logic         en_s2;
  logic         wrap_s2;

  // Register the signed sample alongside its controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_s2    <= '0;
      amp_s2  <= '0;
      en_s2   <= 1'b0;
      wrap_s2 <= 1'b0;
    end else begin
      s_s2    <= s_next;
      amp_s2  <= amp_s1;
      en_s2   <= en_s1;
      wrap_s2 <= wrap_s1;
    end
  end

  // Stage 3: amplitude scaling and offset-binary conversion
  logic [A:0]            gain;
  logic signed [D+A:0]   s_ext;
  logic signed [D+A:0]   gain_ext;
  logic signed [D+A:0]   prod;
  logic signed [D+A:0]   scaled;
  logic [D-1:0]          out_next;

  // Gain (amplitude+1)/2^A with a flooring arithmetic shift
  always_comb begin
    gain     = {1'b0, amp_s2} + {{A{1'b0}}, 1'b1};
    s_ext    = {{(A+1){s_s2[D-1]}}, s_s2};
    gain_ext = {{D{1'b0}}, gain};
    prod     = s_ext * gain_ext;
    scaled   = prod >>> A;
    out_next = MID + scaled[D-1:0];
  end

  // Output register; reset presents midscale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_out   <= MID;
      wave_valid <= 1'b0;
      phase_wrap <= 1'b0;
    end else begin
      wave_out   <= out_next;
      wave_valid <= en_s2;
      phase_wrap <= wrap_s2;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ph_s1, scaled};

endmodule

// File: tb/tb_dds_waveform_generator.sv
// Directed bench for dds_waveform_generator (P=32, L=8, D=8, A=8).
// n counts clock edges since enable first rose; with FTW=2^24 the sample on
// wave_out at edge n belongs to the accumulator value after edge n-3.
module tb_dds_waveform_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] ftw_in;
  logic        ftw_load;
  logic [31:0] phase_offset;
  logic [1:0]  wave_sel;
  logic [7:0]  amplitude;
  logic [7:0]  wave_out;
  logic        wave_valid;
  logic        phase_wrap;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  int r     = 0;

  dds_waveform_generator #(
    .PHASE_WIDTH(32),
    .LUT_ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .AMP_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .ftw_in(ftw_in),
    .ftw_load(ftw_load),
    .phase_offset(phase_offset),
    .wave_sel(wave_sel),
    .amplitude(amplitude),
    .wave_out(wave_out),
    .wave_valid(wave_valid),
    .phase_wrap(phase_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task run_to(input int target);
    while (n < target) tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    ftw_in       = '0;
    ftw_load     = 1'b0;
    phase_offset = '0;
    wave_sel     = 2'd0;
    amplitude    = 8'd255;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", wave_out, 128);
    check("reset_valid", wave_valid, 0);
    check("reset_wrap", phase_wrap, 0);

    // Release, load FTW=2^24, then enable
    rst_n    = 1'b1;
    ftw_in   = 32'h0100_0000;
    ftw_load = 1'b1;
    @(posedge clk);
    #1;
    ftw_load = 1'b0;
    enable   = 1'b1;
    n        = 0;

    // Sine, offset 0, full amplitude
    run_to(2);   check("start_valid_lo", wave_valid, 0);
    run_to(3);   check("start_valid_hi", wave_valid, 1);
                 check("sine_acc0", wave_out, 128);
    run_to(66);  check("sine_peak_a", wave_out, 255);
    run_to(67);  check("sine_peak_b", wave_out, 255);
    run_to(131); check("sine_mid", wave_out, 128);
    run_to(194); check("sine_trough", wave_out, 1);
    run_to(258); check("wrap_before", phase_wrap, 0);
    run_to(259); check("wrap_first", phase_wrap, 1);
                 check("wrap_sample", wave_out, 128);
    run_to(260); check("wrap_after", phase_wrap, 0);
    run_to(515); check("wrap_second", phase_wrap, 1);

    // Quarter-period phase offset shifts the trace by 64 samples
    phase_offset = 32'h4000_0000;
    run_to(771); check("offs_peak", wave_out, 255);
    run_to(835); check("offs_mid", wave_out, 128);
    run_to(898); check("offs_trough", wave_out, 1);

    // Sawtooth follows acc[31:24], code 0 clamped to 1
    phase_offset = '0;
    wave_sel     = 2'd3;
    run_to(901);  check("saw_130", wave_out, 130);
    run_to(1026); check("saw_255", wave_out, 255);
    run_to(1027); check("saw_clamp0", wave_out, 1);
    run_to(1028); check("saw_1", wave_out, 1);
    run_to(1155); check("saw_128", wave_out, 128);

    // Triangle
    wave_sel = 2'd1;
    run_to(1283); check("tri_trough", wave_out, 1);
    run_to(1347); check("tri_rise_mid", wave_out, 128);
    run_to(1411); check("tri_peak", wave_out, 255);
    run_to(1412); check("tri_fall", wave_out, 253);
    run_to(1475); check("tri_fall_mid", wave_out, 127);

    // Square at amplitude 127
    wave_sel  = 2'd2;
    amplitude = 8'd127;
    run_to(1539); check("sq_hi_start", wave_out, 191);
    run_to(1666); check("sq_hi_end", wave_out, 191);
    run_to(1667); check("sq_lo_start", wave_out, 64);
    run_to(1794); check("sq_lo_end", wave_out, 64);
    run_to(1795); check("sq_hi_again", wave_out, 191);

    // Freeze: enable low for 10 edges while on sawtooth
    wave_sel  = 2'd3;
    amplitude = 8'd255;
    run_to(1800);
    enable = 1'b0;
    run_to(1802); check("frz_pre_out", wave_out, 7);
                  check("frz_pre_valid", wave_valid, 1);
    run_to(1803); check("frz_first_valid", wave_valid, 0);
                  check("frz_first_out", wave_out, 8);
    run_to(1807); check("frz_mid_out", wave_out, 8);
                  check("frz_mid_valid", wave_valid, 0);
    run_to(1810);
    enable = 1'b1;
    run_to(1812); check("frz_last_valid", wave_valid, 0);
                  check("frz_last_out", wave_out, 8);
    run_to(1813); check("frz_resume_valid", wave_valid, 1);
                  check("frz_resume_out", wave_out, 8);
    run_to(1814); check("frz_step_out", wave_out, 9);

    // Tuning word change mid-period: 2^24 -> 2^25
    ftw_in   = 32'h0200_0000;
    ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
`ifdef DDS_FTW_SHADOW_EN
    run_to(1818); check("ftw_old_a", wave_out, 13);
    run_to(1819); check("ftw_old_b", wave_out, 14);
    run_to(1820); check("ftw_old_c", wave_out, 15);
    run_to(2060); check("ftw_prewrap", wave_out, 255);
                  check("ftw_prewrap_wrap", phase_wrap, 0);
    run_to(2061); check("ftw_wrap_out", wave_out, 1);
                  check("ftw_wrap_flag", phase_wrap, 1);
    run_to(2062); check("ftw_new_a", wave_out, 2);
    run_to(2063); check("ftw_new_b", wave_out, 4);
`else
    run_to(1818); check("ftw_old", wave_out, 13);
    run_to(1819); check("ftw_new_a", wave_out, 15);
    run_to(1820); check("ftw_new_b", wave_out, 17);
    run_to(1939); check("ftw_prewrap", wave_out, 255);
                  check("ftw_prewrap_wrap", phase_wrap, 0);
    run_to(1940); check("ftw_wrap_out", wave_out, 1);
                  check("ftw_wrap_flag", phase_wrap, 1);

    // Zero tuning word: constant output, still valid, no wraps
    ftw_in   = '0;
    ftw_load = 1'b1;
    tick();
    ftw_load = 1'b0;
    run_to(1950); check("ftw0_out", wave_out, 9);
                  check("ftw0_valid", wave_valid, 1);
                  check("ftw0_wrap", phase_wrap, 0);
    run_to(2300); check("ftw0_out_late", wave_out, 9);
                  check("ftw0_wrap_late", phase_wrap, 0);
`endif

    // Asynchronous reset mid-run with enable high
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", wave_out, 128);
    check("mid_rst_valid", wave_valid, 0);
    check("mid_rst_wrap", phase_wrap, 0);
    tick();
    check("mid_rst_hold", wave_out, 128);
    rst_n = 1'b1;
    r = n;
    run_to(r + 2); check("rel_valid_lo", wave_valid, 0);
                   check("rel_out_mid", wave_out, 128);
    run_to(r + 3); check("rel_valid_hi", wave_valid, 1);
                   check("rel_saw0", wave_out, 1);
    run_to(r + 6); check("rel_ftw_cleared", wave_out, 1);
                   check("rel_wrap", phase_wrap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
